// File: rtl/if_fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, the I-cache request handshake and the IF1/IF2 register controls.
// Optional build macro IF_FETCH_PERF_EN adds the stall_cnt / redirect_cnt performance counters.
module if_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h1c000000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_redirect,
   input  logic [31:0] ex_target,
   input  logic        br_redirect,
   input  logic [31:0] br_target,
   input  logic        bp_taken,
   input  logic [31:0] bp_target,
   input  logic        if2_allowin,
   output logic        ic_req,
   output logic [31:0] ic_addr,
   input  logic        ic_addr_ok,
   input  logic        ic_data_ok,
   output logic [31:0] if1_pc,
   output logic        if1_branch_bp,
   output logic        if1_if2_wen,
`ifdef IF_FETCH_PERF_EN
   output logic [31:0] stall_cnt,
   output logic [31:0] redirect_cnt,
`endif
   output logic        if1_if2_flush
);

   // state   | meaning
   // IDLE    | one cycle after reset release
   // REQ     | request pc_q to the I-cache
   // WAIT    | request accepted, waiting for data
   // HOLD    | data returned but IF2 not ready; I-cache holds it
   // DISCARD | waiting for one stale data_ok to drain
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_REQ     = 3'd1,
      S_WAIT    = 3'd2,
      S_HOLD    = 3'd3,
      S_DISCARD = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic        w_redirect;
   logic [31:0] w_target;
   logic [31:0] w_pc_seq;
   logic        w_deliver;

   assign w_redirect = ex_redirect | br_redirect;
   assign w_target   = ex_redirect ? ex_target : br_target;
   assign w_pc_seq   = bp_taken ? bp_target : (r_pc + PC_STEP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_deliver   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_state_nxt = S_REQ;
            if (w_redirect) w_pc_nxt = w_target;
         end
         S_REQ: begin
            if (w_redirect) begin
               w_pc_nxt    = w_target;
               w_state_nxt = ic_addr_ok ? S_DISCARD : S_REQ;
            end else if (ic_addr_ok) begin
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (w_redirect) begin
               w_pc_nxt    = w_target;
               w_state_nxt = ic_data_ok ? S_REQ : S_DISCARD;
            end else if (ic_data_ok) begin
               if (if2_allowin) begin
                  w_deliver   = 1'b1;
                  w_pc_nxt    = w_pc_seq;
                  w_state_nxt = S_REQ;
               end else begin
                  w_state_nxt = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (w_redirect) begin
               w_pc_nxt    = w_target;
               w_state_nxt = S_REQ;
            end else if (if2_allowin) begin
               w_deliver   = 1'b1;
               w_pc_nxt    = w_pc_seq;
               w_state_nxt = S_REQ;
            end
         end
         S_DISCARD: begin
            // a stale data_ok coinciding with a redirect still drains; otherwise we would wait forever
            if (w_redirect) w_pc_nxt = w_target;
            if (ic_data_ok) w_state_nxt = S_REQ;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign ic_req        = (r_state == S_REQ);
   assign ic_addr       = r_pc;
   assign if1_pc        = r_pc;
   assign if1_if2_wen   = w_deliver | w_redirect;
   assign if1_if2_flush = w_redirect;
   assign if1_branch_bp = w_deliver & bp_taken & ~w_redirect;

`ifdef IF_FETCH_PERF_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_redirect_cnt;
   logic        w_stall;

   assign w_stall = (r_state == S_HOLD) | ((r_state == S_WAIT) & ~ic_data_ok);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt    <= 32'd0;
         r_redirect_cnt <= 32'd0;
      end else begin
         if (w_stall)    r_stall_cnt    <= r_stall_cnt + 32'd1;
         if (w_redirect) r_redirect_cnt <= r_redirect_cnt + 32'd1;
      end
   end

   assign stall_cnt    = r_stall_cnt;
   assign redirect_cnt = r_redirect_cnt;
`endif

endmodule
